// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave: 10-bit words carry opcode + payload.
// Optional build macro SPI_RAM_AUTO_INC_EN makes data commands post-increment their address.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       addr_err
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Payload bits that actually feed an address; anything wider loads as zero.
    localparam int PW = (ADDR_SIZE < 8) ? ADDR_SIZE : 8;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0] addr_payload;
    logic [7:0]           dout_q, dout_d;
    logic                 addr_err_q, addr_err_d;
    logic                 mem_we;
    logic                 wr_in_range, rd_in_range;
    opcode_e              opcode;
    logic [7:0]           mem [0:MEM_DEPTH-1];

`ifdef SPI_RAM_AUTO_INC_EN
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) >= 32'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction
`endif

    assign opcode      = opcode_e'(din[9:8]);
    assign wr_in_range = 32'(wr_addr_q) < 32'(MEM_DEPTH);
    assign rd_in_range = 32'(rd_addr_q) < 32'(MEM_DEPTH);

    always_comb begin
        addr_payload         = '0;
        addr_payload[PW-1:0] = din[PW-1:0];
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        dout_d     = dout_q;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        if (rx_valid) begin
            // Any accepted command ends HOLD; only a fresh read re-enters it.
            state_d = ST_IDLE;
            unique case (opcode)
                OP_WR_ADDR: wr_addr_d = addr_payload;
                OP_WR_DATA: begin
                    mem_we     = wr_in_range;
                    addr_err_d = !wr_in_range;
`ifdef SPI_RAM_AUTO_INC_EN
                    wr_addr_d  = next_addr(wr_addr_q);
`endif
                end
                OP_RD_ADDR: rd_addr_d = addr_payload;
                OP_RD_DATA: begin
                    dout_d     = rd_in_range ? mem[rd_addr_q] : 8'h00;
                    addr_err_d = !rd_in_range;
                    state_d    = ST_HOLD;
`ifdef SPI_RAM_AUTO_INC_EN
                    rd_addr_d  = next_addr(rd_addr_q);
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            dout_q     <= 8'h00;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            dout_q     <= dout_d;
            addr_err_q <= addr_err_d;
        end
    end

    // NOTE: the storage array has no reset so it can map onto plain RAM; the reset
    // term here only discards a write that coincides with reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = (state_q == ST_HOLD);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomised self-checking bench for spi_ram_ctrl against a command-level model.
// Instantiates MEM_DEPTH=200 so out-of-range addresses are reachable.
module tb_spi_ram_ctrl;

    localparam int DEPTH = 200;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit         AUTO      = 1'b1;
    localparam logic [7:0] FIRST_RD  = 8'h11;
`else
    localparam bit         AUTO      = 1'b0;
    localparam logic [7:0] FIRST_RD  = 8'h22;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [9:0] din;
    logic [7:0] dout;
    logic       tx_valid;
    logic       addr_err;

    int checks = 0;
    int errors = 0;

    spi_ram_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command-level reference: one accepted word updates the model state.
    logic [7:0] m_mem [0:255];
    int         m_wr;
    int         m_rd;
    logic [7:0] m_dout;
    logic       m_txv;
    logic       m_err;
    bit         cmp_en = 1'b0;

    function automatic int bump(input int a);
        return (a + 1 < DEPTH) ? a + 1 : 0;
    endfunction

    always @(posedge clk) begin
        m_err = 1'b0;
        if (rst) begin
            m_wr   = 0;
            m_rd   = 0;
            m_dout = 8'h00;
            m_txv  = 1'b0;
        end else if (rx_valid) begin
            m_txv = (din[9:8] == 2'd3);
            case (din[9:8])
                2'd0: m_wr = int'(din[7:0]);
                2'd1: begin
                    if (m_wr < DEPTH) m_mem[m_wr] = din[7:0];
                    else m_err = 1'b1;
                    if (AUTO) m_wr = bump(m_wr);
                end
                2'd2: m_rd = int'(din[7:0]);
                default: begin
                    m_dout = (m_rd < DEPTH) ? m_mem[m_rd] : 8'h00;
                    m_err  = (m_rd >= DEPTH);
                    if (AUTO) m_rd = bump(m_rd);
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("dout", 32'(dout), 32'(m_dout));
            check("tx_valid", 32'(tx_valid), 32'(m_txv));
            check("addr_err", 32'(addr_err), 32'(m_err));
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] pay);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b1;
        din      = {op, pay};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst      = 1'b0;
            rx_valid = 1'b0;
            din      = 10'($urandom);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = '0;
        repeat (2) @(negedge clk);
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_addr_err", 32'(addr_err), 32'h0);
        cmp_en = 1'b1;
        rst    = 1'b0;

        // Fill every in-range word so later reads are fully defined.
        for (int a = 0; a < DEPTH; a++) begin
            send(2'd0, 8'(a));
            send(2'd1, 8'($urandom));
        end

        // Write then read with gaps, HOLD for 20 idle cycles.
        send(2'd0, 8'h2A); idle(1);
        send(2'd1, 8'h5C); idle(1);
        send(2'd2, 8'h2A); idle(1);
        send(2'd3, 8'h00); idle(1);
        check("wr_rd_dout", 32'(dout), 32'h5C);
        check("wr_rd_tx_valid", 32'(tx_valid), 32'h1);
        idle(19);
        check("hold_tx_valid", 32'(tx_valid), 32'h1);
        send(2'd0, 8'h00); idle(1);
        check("hold_exit_tx_valid", 32'(tx_valid), 32'h0);
        check("hold_exit_dout", 32'(dout), 32'h5C);

        // Same four words back to back.
        send(2'd0, 8'h2A);
        send(2'd1, 8'h5C);
        send(2'd2, 8'h2A);
        send(2'd3, 8'h00);
        idle(1);
        check("b2b_dout", 32'(dout), 32'h5C);
        check("b2b_tx_valid", 32'(tx_valid), 32'h1);

        // Out-of-range write and read.
        send(2'd0, 8'hC8);
        send(2'd1, 8'hFF);
        idle(1);
        check("oor_wr_err", 32'(addr_err), 32'h1);
        idle(1);
        check("oor_wr_err_drop", 32'(addr_err), 32'h0);
        send(2'd2, 8'hC8);
        send(2'd3, 8'h00);
        idle(1);
        check("oor_rd_err", 32'(addr_err), 32'h1);
        check("oor_rd_dout", 32'(dout), 32'h00);
        check("oor_rd_tx_valid", 32'(tx_valid), 32'h1);

        // Reset during HOLD; the write presented on the reset edge must be dropped.
        send(2'd2, 8'h2A);
        send(2'd3, 8'h00);
        idle(1);
        check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
        rst      = 1'b1;
        rx_valid = 1'b1;
        din      = {2'd1, 8'h77};
        @(negedge clk);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_dout", 32'(dout), 32'h00);
        rst      = 1'b0;
        rx_valid = 1'b0;
        send(2'd2, 8'h2A);
        send(2'd3, 8'h00);
        idle(1);
        check("post_rst_dout", 32'(dout), 32'h5C);

        // Last in-range word, two writes then two reads (wraps to 0 with auto-increment).
        send(2'd0, 8'(DEPTH - 1));
        send(2'd1, 8'h11);
        send(2'd1, 8'h22);
        send(2'd2, 8'(DEPTH - 1));
        send(2'd3, 8'h00);
        idle(1);
        check("edge_rd1_dout", 32'(dout), 32'(FIRST_RD));
        send(2'd3, 8'h00);
        idle(1);
        check("edge_rd2_dout", 32'(dout), 32'h22);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                @(negedge clk);
                rst      = 1'b1;
                rx_valid = 1'($urandom);
                din      = 10'($urandom);
            end else if (r < 70) begin
                send(2'($urandom), 8'($urandom));
            end else begin
                idle(1);
            end
        end

        // Read back every in-range word.
        for (int a = 0; a < DEPTH; a++) begin
            send(2'd2, 8'(a));
            send(2'd3, 8'h00);
            idle(1);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
